count_event_capture: RTL
========================

Name: count_event_capture

Overview:
- Sits directly downstream of the 5-bit signed up counter.
- Samples the signed count on a strobe and detects three events: wrap-around (max positive to most negative), upward threshold crossing, and return to zero.
- Each detected event becomes a record {code, count}, buffered in a small FIFO and presented on a valid/ready interface to the host/debug logic.
- Full-FIFO drops are flagged by a sticky error bit.

Parameters:
- CNT_W, 5: width of the signed count input.
- DEPTH, 4: FIFO depth in records; power of two, ≥2.
- THRESH, 10: signed threshold, CNT_W bits, for upward-crossing detection.
- TS_W, 16: timestamp width; used only with CEC_TIMESTAMP_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- count_in  in  CNT_W  signed count from the upstream counter.
- count_vld  in  1  sample strobe; count_in is evaluated only when this is 1.
- ev_valid  out  1  FIFO head record valid.
- ev_ready  in  1  consumer accepts the head record when ev_valid && ev_ready.
- ev_code  out  2  event code of the head record.
- ev_count  out  CNT_W  signed count captured with the event.
- ev_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- drop_err  out  1  sticky flag: a record was lost because the FIFO was full.
- drop_clr  in  1  synchronous clear for drop_err.
- ev_ts  out  TS_W  timestamp of the head record; present only with CEC_TIMESTAMP_EN.

Behaviour:
- Reset (async, active-high; clock clk):
  - ev_valid=0, ev_level=0, drop_err=0, ev_code=0, ev_count=0.
  - prev_cnt=0, hist_vld=0, FIFO pointers=0.
- History:
  - On an edge with count_vld=1: prev_cnt<=count_in, hist_vld<=1.
  - The first sample after reset only loads history; it generates no event.
- Detection is combinational on count_in vs prev_cnt, and is qualified by count_vld && hist_vld:
  - WRAP (2'b01): prev_cnt == +2^(CNT_W-1)-1 and count_in == -2^(CNT_W-1). Default is 15 → -16.
  - THRESH (2'b10): prev_cnt < THRESH and count_in >= THRESH. Signed compare.
  - ZERO (2'b11): count_in == 0 and prev_cnt != 0.
  - Priority WRAP > THRESH > ZERO; at most one record per sample.
  - Equal consecutive samples produce no event.
- Push:
  - The record is written at the same edge the sample is taken.
  - ev_valid rises in the cycle after the sampling edge when the FIFO was empty. Latency is 1 clock.
- Pop:
  - Occurs on an edge with ev_valid && ev_ready.
  - The head is combinational from the FIFO array and read pointer.
  - ev_code/ev_count are held stable while ev_valid=1 and ev_ready=0.
- Full:
  - A push with ev_level==DEPTH and no simultaneous pop is discarded and sets drop_err<=1.
  - With a simultaneous pop, the push is accepted and the level is unchanged.
- Empty: ev_ready is ignored; ev_code/ev_count hold their last values.
- drop_err:
  - drop_clr=1 clears drop_err.
  - If a drop occurs in the same cycle as drop_clr, set wins and drop_err=1.
- Pointers: wrap modulo DEPTH; ev_level counts 0..DEPTH.
- Reset mid-operation: all stored records are discarded and history is invalidated. The first post-reset sample generates no event.

Optional Feature:
- CEC_TIMESTAMP_EN defined:
  - A TS_W-bit free-running cycle counter is added; it resets to 0 and wraps modulo 2^TS_W.
  - Its value at the push edge is stored with each record and output on ev_ts.
- Not defined: no timestamp counter, no ev_ts port, and no timestamp storage.

Decomposition:
- Package cec_pkg holds:
  - Event code constants EVT_NONE=2'b00, EVT_WRAP=2'b01, EVT_THRESH=2'b10, EVT_ZERO=2'b11.
  - A record-width localparam: 2+CNT_W, plus TS_W when CEC_TIMESTAMP_EN is defined.
- Sub-module cec_sync_fifo: parameterised width/depth, push/pop/full/empty/level, with the same asynchronous reset.
- The detection logic and drop flag stay in the top module.

Test Plan:
- Counter sweep: reset, then count_vld=1 every cycle with count_in 0,1,…,15,-16,-15,…,-1,0 and ev_ready=1.
  - Exactly three records: THRESH/10, WRAP/-16, ZERO/0.
  - No record for the first sample (0).
- Backpressure: ev_ready=0, then five events (sweep through 10, -16, 0, then 10, -16).
  - ev_level=4 and drop_err=1.
  - Head stays THRESH/10.
  - drop_clr pulse → drop_err=0.
- Full with simultaneous pop/push: FIFO full, ev_ready=1 on the edge an event occurs.
  - Event is accepted, ev_level stays 4, drop_err stays 0.
- Reset mid-operation: two records stored, assert reset asynchronously between edges.
  - ev_valid=0 and ev_level=0 immediately.
  - Next sample 10 after prev-less history → no record.
- Strobe gating: count_vld=0 while count_in goes 9→10→15→-16.
  - No records; history unchanged.
- With CEC_TIMESTAMP_EN: THRESH crossing at cycle 12 after reset release → ev_ts=12; WRAP at cycle 18 → ev_ts=18.

Source files
------------

// File: rtl/cec_pkg.sv
// Shared event codes and record sizing for count_event_capture.
// CEC_TIMESTAMP_EN widens each record with a cycle timestamp.
package cec_pkg;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_WRAP   = 2'b01;
  localparam logic [1:0] EVT_THRESH = 2'b10;
  localparam logic [1:0] EVT_ZERO   = 2'b11;

  localparam int unsigned CEC_CNT_W = 5;
  localparam int unsigned CEC_TS_W  = 16;

`ifdef CEC_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Record layout, MSB first: {ts (optional), code, count}.
  function automatic int unsigned rec_width(input int unsigned cnt_w, input int unsigned ts_w);
    return 2 + cnt_w + (TS_EN ? ts_w : 0);
  endfunction

  localparam int unsigned CEC_REC_W = rec_width(CEC_CNT_W, CEC_TS_W);

endpackage

// File: rtl/cec_sync_fifo.sv
// Small synchronous FIFO with occupancy count and a combinational head.
// While empty the head shows the most recently popped entry.
module cec_sync_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;
  localparam logic [AW:0]   LVL_MAX = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_idx;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_MAX);
  assign level   = level_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // The slot behind the read pointer is untouched until the FIFO refills past it.
  assign rd_idx = empty ? (rd_ptr_q - PTR_ONE) : rd_ptr_q;
  assign rdata  = mem_q[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/count_event_capture.sv
// Detects wrap, upward-threshold and return-to-zero events on a sampled signed count
// and queues {code, count} records; CEC_TIMESTAMP_EN adds a per-record cycle stamp.
module count_event_capture
  import cec_pkg::*;
#(
  parameter int unsigned CNT_W  = CEC_CNT_W,
  parameter int unsigned DEPTH  = 4,
  parameter int          THRESH = 10,
  parameter int unsigned TS_W   = CEC_TS_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [CNT_W-1:0]     count_in,
  input  logic                        count_vld,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [1:0]                  ev_code,
  output logic signed [CNT_W-1:0]     ev_count,
  output logic [$clog2(DEPTH):0]      ev_level,
  output logic                        drop_err,
  input  logic                        drop_clr
`ifdef CEC_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]             ev_ts
`endif
);

  localparam int unsigned REC_W = rec_width(CNT_W, TS_W);

  localparam logic signed [CNT_W-1:0] MAX_POS = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] MIN_NEG = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] THR     = THRESH[CNT_W-1:0];

  logic signed [CNT_W-1:0] prev_cnt_q;
  logic                    hist_vld_q;
  logic [1:0]              det_code;
  logic                    push, full, empty, drop;
  logic [REC_W-1:0]        wr_rec, rd_rec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_cnt_q <= '0;
      hist_vld_q <= 1'b0;
    end else if (count_vld) begin
      prev_cnt_q <= count_in;
      hist_vld_q <= 1'b1;
    end
  end

  always_comb begin
    det_code = EVT_NONE;
    if (count_vld && hist_vld_q) begin
      if (prev_cnt_q == MAX_POS && count_in == MIN_NEG) begin
        det_code = EVT_WRAP;
      end else if (prev_cnt_q < THR && count_in >= THR) begin
        det_code = EVT_THRESH;
      end else if (count_in == '0 && prev_cnt_q != '0) begin
        det_code = EVT_ZERO;
      end
    end
  end

  assign push = (det_code != EVT_NONE);
  // Full implies non-empty, so a concurrent ready always frees a slot.
  assign drop = push && full && !ev_ready;

`ifdef CEC_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end

  assign wr_rec = {ts_q, det_code, count_in};
  assign ev_ts  = rd_rec[REC_W-1 -: TS_W];
`else
  assign wr_rec = {det_code, count_in};
`endif

  cec_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wr_rec),
    .pop   (ev_ready),
    .rdata (rd_rec),
    .full  (full),
    .empty (empty),
    .level (ev_level)
  );

  assign ev_valid = !empty;
  assign ev_code  = rd_rec[CNT_W +: 2];
  assign ev_count = rd_rec[CNT_W-1:0];

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_err <= 1'b0;
    end else if (drop) begin
      drop_err <= 1'b1;
    end else if (drop_clr) begin
      drop_err <= 1'b0;
    end
  end

endmodule
